// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_t      : sequencer state (RUN, DIV, EXC)
//   *_IDX        : bit index of each pipeline register in o_we / o_flush
//   WE_* / FLUSH_*: per-request enable and clear patterns
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    DIV = 2'd1,
    EXC = 2'd2
  } state_t;

  localparam int NSTAGE    = 5;
  localparam int PC_IDX    = 0;
  localparam int IFID_IDX  = 1;
  localparam int IDEX_IDX  = 2;
  localparam int EXMEM_IDX = 3;
  localparam int MEMWB_IDX = 4;

  localparam logic [NSTAGE-1:0] WE_ALL    = '1;
  localparam logic [NSTAGE-1:0] FLUSH_EXC = WE_ALL & ~NSTAGE'(1 << PC_IDX);

  // A stalled stage holds, and the first stage downstream of the stall
  // is loaded with a bubble; every stage further downstream keeps moving.
  localparam logic [NSTAGE-1:0] FLUSH_BRANCH  = NSTAGE'(1 << IFID_IDX);
  localparam logic [NSTAGE-1:0] FLUSH_LOADUSE = NSTAGE'(1 << IDEX_IDX);
  localparam logic [NSTAGE-1:0] FLUSH_DIV     = NSTAGE'(1 << EXMEM_IDX);
  localparam logic [NSTAGE-1:0] FLUSH_MEMWAIT = NSTAGE'(1 << MEMWB_IDX);
  localparam logic [NSTAGE-1:0] WE_LOADUSE    = NSTAGE'(7 << IDEX_IDX);
  localparam logic [NSTAGE-1:0] WE_DIV        = NSTAGE'(3 << EXMEM_IDX);
  localparam logic [NSTAGE-1:0] WE_MEMWAIT    = FLUSH_MEMWAIT;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Request/control bundle between the hazard sources and the sequencer.
//   i_load_use, i_div_start, i_mem_wait, i_branch_taken, i_exception : requests
//   o_we[4:0], o_flush[4:0]  : per-stage load enable / synchronous clear
//   o_pc_sel_exc             : PC loads exception vector
//   o_div_busy, o_div_done, o_div_abort : divider status
// Modports: master = request side, slave = pipeline_ctrl.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic              i_load_use;
  logic              i_div_start;
  logic              i_mem_wait;
  logic              i_branch_taken;
  logic              i_exception;
  logic [NSTAGE-1:0] o_we;
  logic [NSTAGE-1:0] o_flush;
  logic              o_pc_sel_exc;
  logic              o_div_busy;
  logic              o_div_done;
  logic              o_div_abort;

  modport master (
    output i_load_use, i_div_start, i_mem_wait, i_branch_taken, i_exception,
    input  o_we, o_flush, o_pc_sel_exc, o_div_busy, o_div_done, o_div_abort
  );

  modport slave (
    input  i_load_use, i_div_start, i_mem_wait, i_branch_taken, i_exception,
    output o_we, o_flush, o_pc_sel_exc, o_div_busy, o_div_done, o_div_abort
  );

endinterface

// File: rtl/pipeline_ctrl_cnt.sv
// pipeline_ctrl_cnt
// Loadable down-counter that stops at zero; shared by the divide and
// exception-shadow sequences.
//   clk, resetn : clock, synchronous active-low reset (clears to 0)
//   load, load_val : load has priority over dec
//   dec         : decrement, holds at 0
//   zero        : count == 0
module pipeline_ctrl_cnt #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage core. Resolves exception,
// memory-wait, divide, branch and load-use requests into one per-cycle
// write-enable / synchronous-clear pattern for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//   DIV_CYCLES (>=2) : divider latency; EXC_CYCLES (>=1) : exception shadow
//   clk, resetn      : clock, synchronous active-low reset
//   bus (slave)      : requests in, enables/clears/status out
//   o_stall_cycles   : only when PIPE_CTRL_PERF_EN is defined; saturating
//                      count of cycles with the PC held
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int EXC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  pipeline_ctrl_if.slave    bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);

  localparam int MAXC  = (DIV_CYCLES > EXC_CYCLES) ? DIV_CYCLES : EXC_CYCLES;
  localparam int CNT_W = $clog2(MAXC) + 1;

  state_t            state, next_state;
  logic [NSTAGE-1:0] we, flush;
  logic              pc_sel_exc, div_busy, div_done, div_abort;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;

  pipeline_ctrl_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // One if/else chain encodes the request priority. The EXC shadow sits
  // first so that every request, including a nested exception, is ignored.
  always_comb begin
    we         = WE_ALL;
    flush      = '0;
    pc_sel_exc = 1'b0;
    div_busy   = 1'b0;
    div_done   = 1'b0;
    div_abort  = 1'b0;
    next_state = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    if (!resetn) begin
      flush      = WE_ALL;
      next_state = RUN;
    end else if (state == EXC) begin
      flush = FLUSH_EXC;
      if (cnt_zero) begin
        next_state = RUN;
      end else begin
        cnt_dec = 1'b1;
      end
    end else if (bus.i_exception) begin
      flush      = FLUSH_EXC;
      pc_sel_exc = 1'b1;
      div_abort  = (state == DIV);
      div_busy   = (state == DIV);
      cnt_load   = 1'b1;
      cnt_val    = CNT_W'(EXC_CYCLES - 1);
      next_state = EXC;
    end else if (bus.i_mem_wait) begin
      // The divider keeps running while MEM waits; the counter stops at 0,
      // so a wait that overlaps the release cycle simply delays it.
      we       = WE_MEMWAIT;
      flush    = FLUSH_MEMWAIT;
      div_busy = (state == DIV);
      cnt_dec  = (state == DIV);
    end else if (state == DIV) begin
      if (!cnt_zero) begin
        we       = WE_DIV;
        flush    = FLUSH_DIV;
        div_busy = 1'b1;
        cnt_dec  = 1'b1;
      end else begin
        div_done   = 1'b1;
        next_state = RUN;
      end
    end else if (bus.i_div_start) begin
      we         = WE_DIV;
      flush      = FLUSH_DIV;
      div_busy   = 1'b1;
      cnt_load   = 1'b1;
      cnt_val    = CNT_W'(DIV_CYCLES - 1);
      next_state = DIV;
    end else if (bus.i_branch_taken) begin
      // Wins over load-use: the dependent instruction is on the wrong path.
      flush = FLUSH_BRANCH;
    end else if (bus.i_load_use) begin
      we    = WE_LOADUSE;
      flush = FLUSH_LOADUSE;
    end
  end

  assign bus.o_we         = we;
  assign bus.o_flush      = flush;
  assign bus.o_pc_sel_exc = pc_sel_exc;
  assign bus.o_div_busy   = div_busy;
  assign bus.o_div_done   = div_done;
  assign bus.o_div_abort  = div_abort;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (!we[PC_IDX] && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl with DIV_CYCLES=4, EXC_CYCLES=2.
// Directed scenarios followed by random request traffic, all compared
// each cycle against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

  localparam int DIVC = 4;
  localparam int EXCC = 2;

  logic clk = 1'b0;
  logic resetn;
  pipeline_ctrl_if bus ();
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Model: whether a divide is outstanding, how many countdown steps it has
  // left, how many shadow cycles remain after an exception, stall count.
  bit          m_div;
  int          m_div_left;
  int          m_exc_left;
  longint      m_stalls;

  logic [4:0]  e_we, e_flush;
  logic        e_pc, e_busy, e_done, e_abort;
  logic [31:0] e_stall;

  pipeline_ctrl #(.DIV_CYCLES(DIVC), .EXC_CYCLES(EXCC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs for this cycle from the current model, then advance
  // the model to what it should be after the coming clock edge.
  task automatic modelCycle(input bit rn, ld, dv, mw, br, ex);
    e_we    = 5'b11111;
    e_flush = 5'b00000;
    e_pc    = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_abort = 1'b0;
    e_stall = m_stalls[31:0];
    if (!rn) begin
      e_flush    = 5'b11111;
      m_div      = 1'b0;
      m_div_left = 0;
      m_exc_left = 0;
    end else if (m_exc_left > 0) begin
      e_flush    = 5'b11110;
      m_exc_left = m_exc_left - 1;
    end else if (ex) begin
      e_flush    = 5'b11110;
      e_pc       = 1'b1;
      e_abort    = m_div;
      e_busy     = m_div;
      m_div      = 1'b0;
      m_exc_left = EXCC;
    end else if (mw) begin
      e_we    = 5'b10000;
      e_flush = 5'b10000;
      e_busy  = m_div;
      if (m_div && m_div_left > 0) m_div_left = m_div_left - 1;
    end else if (m_div && m_div_left > 0) begin
      e_we       = 5'b11000;
      e_flush    = 5'b01000;
      e_busy     = 1'b1;
      m_div_left = m_div_left - 1;
    end else if (m_div) begin
      e_done = 1'b1;
      m_div  = 1'b0;
    end else if (dv) begin
      e_we       = 5'b11000;
      e_flush    = 5'b01000;
      e_busy     = 1'b1;
      m_div      = 1'b1;
      m_div_left = DIVC - 1;
    end else if (br) begin
      e_flush = 5'b00010;
    end else if (ld) begin
      e_we    = 5'b11100;
      e_flush = 5'b00100;
    end
    if (!rn) m_stalls = 0;
    else if (!e_we[0] && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkField(tag, "we",    32'(bus.o_we),         32'(e_we));
    checkField(tag, "flush", 32'(bus.o_flush),      32'(e_flush));
    checkField(tag, "pcexc", 32'(bus.o_pc_sel_exc), 32'(e_pc));
    checkField(tag, "busy",  32'(bus.o_div_busy),   32'(e_busy));
    checkField(tag, "done",  32'(bus.o_div_done),   32'(e_done));
    checkField(tag, "abort", 32'(bus.o_div_abort),  32'(e_abort));
`ifdef PIPE_CTRL_PERF_EN
    checkField(tag, "stall", stall_cycles,          e_stall);
`endif
  endtask

  // Drive one cycle of inputs away from the active edge, then check.
  task automatic applyStimulus(input string tag, input bit rn, ld, dv, mw, br, ex);
    @(negedge clk);
    resetn             = rn;
    bus.i_load_use     = ld;
    bus.i_div_start    = dv;
    bus.i_mem_wait     = mw;
    bus.i_branch_taken = br;
    bus.i_exception    = ex;
    #2;
    modelCycle(rn, ld, dv, mw, br, ex);
    checkOutput(tag);
  endtask

  initial begin
    resetn             = 1'b0;
    bus.i_load_use     = 1'b0;
    bus.i_div_start    = 1'b0;
    bus.i_mem_wait     = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_exception    = 1'b0;
    m_div      = 1'b0;
    m_div_left = 0;
    m_exc_left = 0;
    m_stalls   = 0;

    $display("[TB] reset");
    applyStimulus("reset0", 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 0, 1, 1, 1, 1, 1);
    applyStimulus("idle",   1, 0, 0, 0, 0, 0);

    $display("[TB] load-use");
    applyStimulus("ldu",      1, 1, 0, 0, 0, 0);
    applyStimulus("ldu_next", 1, 0, 0, 0, 0, 0);

    $display("[TB] divide");
    applyStimulus("div_start", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("div_run", 1, 0, 0, 0, 0, 0);

    $display("[TB] divide with memory wait");
    applyStimulus("divw_start", 1, 0, 1, 0, 0, 0);
    applyStimulus("divw_s2",    1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("divw_wait", 1, 0, 0, 1, 0, 0);
    applyStimulus("divw_rel",   1, 0, 0, 0, 0, 0);
    applyStimulus("divw_idle",  1, 0, 0, 0, 0, 0);

    $display("[TB] exception during divide");
    applyStimulus("dexc_start", 1, 0, 1, 0, 0, 0);
    applyStimulus("dexc_d1",    1, 0, 0, 0, 0, 0);
    applyStimulus("dexc_exc",   1, 0, 0, 0, 0, 1);
    applyStimulus("dexc_sh1",   1, 1, 1, 0, 1, 1);
    applyStimulus("dexc_sh2",   1, 0, 0, 0, 1, 0);
    applyStimulus("dexc_after", 1, 0, 0, 0, 1, 0);
    applyStimulus("dexc_idle",  1, 0, 0, 0, 0, 0);

    $display("[TB] branch with load-use");
    applyStimulus("br_ldu", 1, 1, 0, 0, 1, 0);

    $display("[TB] reset during divide");
    applyStimulus("rdiv_start", 1, 0, 1, 0, 0, 0);
    applyStimulus("rdiv_d1",    1, 0, 0, 0, 0, 0);
    applyStimulus("rdiv_rst",   0, 0, 0, 0, 0, 0);
    applyStimulus("rdiv_after", 1, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. Drives the write-enable and synchronous-clear inputs of the five pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, all write-enable register instances). Resolves hazard, multi-cycle divide, memory-wait and exception requests into one consistent per-cycle stall/bubble pattern.

## Interface
- DIV_CYCLES, 32, cycles the divider needs; ≥2
- EXC_CYCLES, 2, length of exception shadow; ≥1
- clk  in  1  clock
- resetn  in  1  reset: synchronous, active-low (clock clk)
- i_load_use  in  1  ID consumes a load result currently in EX
- i_div_start  in  1  EX issues a divide this cycle
- i_mem_wait  in  1  MEM access not complete
- i_branch_taken  in  1  EX resolved a taken branch/jump
- i_exception  in  1  MEM instruction raised an exception
- o_we  out  5  load enable; bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB
- o_flush  out  5  synchronous clear, same indexing; only meaningful with matching o_we=1
- o_pc_sel_exc  out  1  PC loads exception vector
- o_div_busy  out  1  divide stall in progress
- o_div_done  out  1  one-cycle pulse: divide result consumed, EX advances
- o_div_abort  out  1  one-cycle pulse: divide cancelled by exception

## Operation
- States: RUN, DIV, EXC. Registered state plus one shared down-counter `cnt`; all outputs combinational from state, cnt, inputs.
- Default (no request): o_we=5'b11111, o_flush=0.
- Priority per cycle, highest first:
  - Exception (RUN or DIV): o_we=11111, o_flush=11110, o_pc_sel_exc=1; cnt←EXC_CYCLES-1; next EXC. In DIV also pulse o_div_abort.
  - Memory wait: o_we=10000, o_flush=10000 (bubble into WB, everything else holds). cnt still decrements in DIV, but not below 0.
  - Divide (RUN with i_div_start, or DIV with cnt≠0): o_we=11000, o_flush=01000 (bubble into MEM). On entry cnt←DIV_CYCLES-1, next DIV. In DIV, cnt decrements.
  - DIV with cnt=0: o_div_done=1, default enables, next RUN.
  - Taken branch: o_we=11111, o_flush=00010 (kill wrong-path IF/ID).
  - Load-use: o_we=11100, o_flush=00100 (bubble into EX).
- Branch and load-use together: branch wins, because the load-use consumer is wrong-path.
- EXC: o_we=11111, o_flush=11110. i_div_start, i_branch_taken, i_load_use and a nested i_exception are all ignored. cnt decrements; at cnt=0 next RUN.
- o_div_busy=1 in the RUN start cycle and in every DIV cycle except the release cycle.

## Timing
- Reset (resetn=0): state RUN, cnt=0, o_we=11111, o_flush=11111, all pulses 0.
- Divide stall length: exactly DIV_CYCLES cycles (start cycle plus DIV_CYCLES-1 DIV cycles). Release cycle follows, plus one extra cycle per memory-wait cycle that lands on cnt=0.
- Exception: redirect occurs in the exception cycle. Shadow lasts EXC_CYCLES following cycles.
- Request inputs are sampled combinationally in the same cycle. No input registering.
- Reset mid-DIV/EXC: abandons the operation with no o_div_abort pulse.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds port o_stall_cycles, out, 32 bits. It counts cycles with o_we[0]=0 (resetn=1 only), saturates at 32'hFFFF_FFFF, and is cleared by reset.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Package pipeline_ctrl_pkg: state enum (RUN, DIV, EXC); stage index constants (PC_IDX=0 … MEMWB_IDX=4); constant patterns WE_ALL, FLUSH_EXC.
- One sub-module, pipeline_ctrl_cnt: loadable saturating-at-zero down-counter with load/dec/zero flag. It is shared by DIV and EXC.

## Test plan
- Load-use alone for 1 cycle → o_we=11100, o_flush=00100 that cycle; defaults next cycle.
- i_div_start with DIV_CYCLES=4 → o_div_busy high 4 cycles with o_we=11000 each; o_div_done on the 5th cycle with o_we=11111.
- Divide with i_mem_wait asserted for 3 cycles starting in the 3rd stall cycle → o_we=10000 during the wait; o_div_done delayed until wait drops and cnt=0.
- i_exception in the 2nd DIV cycle → o_div_abort and o_pc_sel_exc pulse, o_flush=11110; EXC_CYCLES=2 shadow ignores i_branch_taken.
- i_branch_taken and i_load_use together → o_we=11111, o_flush=00010.
- resetn low during DIV → next cycle state RUN, o_div_busy=0; with PIPE_CTRL_PERF_EN, o_stall_cycles=0.
